// File: rtl/line_memory_ctrl_pkg.sv
// Shared constants and types for the line memory controller.
package line_memory_ctrl_pkg;

    localparam int unsigned LINE_W          = 256;
    localparam int unsigned OFFSET_W        = 5;   // byte offset within a 32-byte line
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned LATENCY_DEFAULT = 10;
    localparam int unsigned DEPTH_DEFAULT   = 512;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/line_memory_ctrl_array.sv
// Line storage: one synchronous write port, one combinational read port, no reset.
module line_mem_array
    import line_memory_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem_q [DEPTH];

    // Write port: commit one full line per enabled edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: asynchronous lookup.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/line_memory_ctrl.sv
// Fixed-latency line memory front end: latches one request, waits LATENCY cycles,
// pulses ack_o, and services the line array.
module line_memory_ctrl
    import line_memory_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = LATENCY_DEFAULT,
    parameter int unsigned DEPTH   = DEPTH_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;

    logic [LINE_W-1:0] mem_rdata;
    logic              mem_we;

    // Offset bits and bits above the index are deliberately dropped (address wraps).
    logic unused_addr;
    assign unused_addr = ^addr_i;

    line_mem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (idx_q),
        .rdata_o (mem_rdata)
    );

    // Next-state logic: accept in IDLE, count in WAIT, complete in ACK.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable_i) begin
                    idx_d   = addr_i[OFFSET_W +: IDX_W];
                    wr_d    = write_i;
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ACK;
                    // Reads present their data for the whole ACK cycle and hold it after.
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end
                end
            end
            ACK: begin
                // Write commits on the edge leaving ACK, so a reset in ACK aborts it.
                mem_we  = wr_q;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and request latches with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs decoded straight from registers.
    always_comb begin
        ack_o  = (state_q == ACK);
        data_o = rdata_q;
    end

endmodule

// File: tb/tb_line_memory_ctrl.sv
// Directed bench for line_memory_ctrl with a scoreboard of expected completions.
module tb_line_memory_ctrl;

    localparam int unsigned L     = 10;
    localparam int unsigned DEPTH = 512;

    logic         clk_i;
    logic         rst_i;
    logic         enable_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         ack_o;
    logic [255:0] data_o;

    line_memory_ctrl #(
        .LATENCY (L),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    typedef struct {
        bit           rd;
        int unsigned  idx;
        logic [255:0] data;
        int           t0;
    } exp_t;

    exp_t         sb[$];
    logic [255:0] model [DEPTH];
    logic [255:0] last_read;
    int           cyc;
    int           checks;
    int           failures;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request at a negedge while the DUT is idle; it is accepted at the next edge.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [255:0] d);
        exp_t e;
        enable_i = 1'b1;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        e.rd   = !wr;
        e.idx  = (a >> 5) % DEPTH;
        e.data = wr ? d : model[e.idx];
        e.t0   = cyc + 1;
        sb.push_back(e);
    endtask

    // Wait (bounded) for ack_o, check the head of the scoreboard, then check the pulse ends.
    task automatic wait_ack(input bit keep_en);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        @(negedge clk_i);
        if (!keep_en) enable_i = 1'b0;
        for (int i = 0; i < int'(L) + 5 && !seen; i++) begin
            if (ack_o === 1'b1) seen = 1'b1;
            else @(negedge clk_i);
        end
        e = sb.pop_front();
        chk("ack_seen", 256'(seen), 256'(1));
        if (seen) begin
            // ack_o high here is sampled by edge t0+L
            chk("ack_latency", 256'(cyc + 1 - e.t0), 256'(L));
            if (e.rd) begin
                chk("read_data", data_o, e.data);
                last_read = e.data;
            end else begin
                chk("write_holds_data_o", data_o, last_read);
                model[e.idx] = e.data;
            end
            @(negedge clk_i);
            chk("ack_one_cycle", 256'(ack_o), 256'(0));
        end
    endtask

    initial begin
        exp_t dropped;
        checks    = 0;
        failures  = 0;
        cyc       = 0;
        last_read = '0;
        rst_i     = 1'b0;
        enable_i  = 1'b1;
        write_i   = 1'b1;
        addr_i    = 32'h40;
        data_i    = '1;

        // Reset holds everything idle even with a request presented.
        repeat (3) begin
            @(negedge clk_i);
            chk("reset_ack", 256'(ack_o), 256'(0));
            chk("reset_data", data_o, 256'(0));
        end
        enable_i = 1'b0;
        rst_i    = 1'b1;

        // Write then read-back of the same line, issued immediately after.
        @(negedge clk_i);
        issue(1'b1, 32'h0000_0040, {32{8'hA5}});
        wait_ack(1'b0);
        issue(1'b0, 32'h0000_0040, '0);
        wait_ack(1'b0);

        // Address aliasing: upper bits and byte offset ignored.
        issue(1'b1, 32'h0000_4020, 256'h1);
        wait_ack(1'b0);
        issue(1'b0, 32'h0000_0020, '0);
        wait_ack(1'b0);
        issue(1'b0, 32'h0000_0021, '0);
        wait_ack(1'b0);

        // Input churn during WAIT must not turn the read into a write of line 4.
        issue(1'b1, 32'h0000_0080, {8{32'hDEADBEEF}});
        wait_ack(1'b0);
        issue(1'b0, 32'h0000_0040, '0);
        @(negedge clk_i);
        addr_i  = 32'h0000_0080;
        write_i = 1'b1;
        data_i  = '1;
        wait_ack(1'b0);
        issue(1'b0, 32'h0000_0080, '0);
        wait_ack(1'b0);

        // Reset in the middle of a write aborts it; old line contents survive.
        issue(1'b1, 32'h0000_0060, {16{16'h3333}});
        wait_ack(1'b0);
        issue(1'b1, 32'h0000_0060, {16{16'hC0DE}});
        @(negedge clk_i);
        enable_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("async_reset_data", data_o, 256'(0));
        chk("async_reset_ack", 256'(ack_o), 256'(0));
        last_read = '0;
        dropped   = sb.pop_front();
        repeat (L + 2) begin
            @(negedge clk_i);
            chk("abort_no_ack", 256'(ack_o), 256'(0));
        end
        rst_i = 1'b1;
        issue(1'b0, 32'h0000_0060, '0);
        wait_ack(1'b0);

        // Back-to-back reads with enable held high: acks at t0+10, t0+21, t0+32.
        issue(1'b0, 32'h0000_0020, '0);
        wait_ack(1'b1);
        issue(1'b0, 32'h0000_0040, '0);
        wait_ack(1'b1);
        issue(1'b0, 32'h0000_0080, '0);
        wait_ack(1'b0);

        // data_o holds the line-3 read through a later write's ACK.
        issue(1'b0, 32'h0000_0060, '0);
        wait_ack(1'b0);
        issue(1'b1, 32'h0000_0080, {4{64'h0123_4567_89AB_CDEF}});
        wait_ack(1'b0);
        issue(1'b0, 32'h0000_0080, '0);
        wait_ack(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
